// File: rtl/trig_cmd_scheduler.sv
// Trigger-line command scheduler: arbitrates reset/align/preL1/L1 frames onto one
// serial line and schedules each preL1's L1 a fixed latency later via a due-time FIFO.
module trig_cmd_scheduler #(
    parameter int L1_DELAY = 325,
    parameter int DEPTH    = 8,
    parameter int TS_W     = 16,
    parameter int TS_INIT  = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ena_i,
    input  logic                     req_reset_i,
    input  logic                     req_align_i,
    input  logic                     req_pre_i,
    input  logic                     ps_flag_i,
    output logic                     ack_reset_o,
    output logic                     ack_align_o,
    output logic                     ack_pre_o,
    output logic                     trigger_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic [15:0]              pre_count_o,
    output logic [15:0]              l1_count_o,
    output logic                     late_err_o,
    output logic                     dbg_state_o
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [3:0] PAT_PRE   = 4'b1110;
    localparam logic [3:0] PAT_L1    = 4'b1000;
    localparam logic [3:0] PAT_L1PS  = 4'b1100;
    localparam logic [3:0] PAT_ALIGN = 4'b1010;
    localparam logic [3:0] PAT_RESET = 4'b1111;

    logic [0:0]      state_q, state_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      pat_q, pat_d;
    logic            trig_q, trig_d;
    logic            busy_q, busy_d;
    logic            ack_reset_q, ack_align_q, ack_pre_q;
    logic [TS_W-1:0] now_q, now_d;
    logic [TS_W:0]   fifo_mem [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic [15:0]     pre_cnt_q, l1_cnt_q;
    logic            late_q;

    logic [TS_W-1:0] head_ts, since;
    logic            head_ps, fifo_empty, fifo_full, l1_due, can_grant;
    logic            gnt_reset, gnt_l1, gnt_align, gnt_pre, any_gnt;

    // Grant decisions use the timestamp of the cycle in which b1 will be driven.
    assign now_d      = now_q + 1'b1;
    assign head_ts    = fifo_mem[rd_q][TS_W:1];
    assign head_ps    = fifo_mem[rd_q][0];
    assign since      = now_d - head_ts;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));
    assign l1_due     = !fifo_empty && !since[TS_W-1];
    assign can_grant  = (state_q == ST_IDLE) || (bit_q == 3'd5);

    assign gnt_reset = can_grant && ena_i && req_reset_i;
    assign gnt_l1    = can_grant && !gnt_reset && l1_due;
    assign gnt_align = can_grant && ena_i && req_align_i && !gnt_reset && !l1_due;
    assign gnt_pre   = can_grant && ena_i && req_pre_i && !req_align_i && !fifo_full
                       && !gnt_reset && !l1_due;
    assign any_gnt   = gnt_reset || gnt_l1 || gnt_align || gnt_pre;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        pat_d   = pat_q;
        busy_d  = busy_q;
        trig_d  = 1'b0;
        if (any_gnt) begin
            state_d = ST_SEND;
            bit_d   = 3'd1;
            busy_d  = 1'b1;
            if (gnt_reset)      pat_d = PAT_RESET;
            else if (gnt_l1)    pat_d = head_ps ? PAT_L1PS : PAT_L1;
            else if (gnt_align) pat_d = PAT_ALIGN;
            else                pat_d = PAT_PRE;
            trig_d = pat_d[3];
        end else if (state_q == ST_SEND) begin
            if (bit_q == 3'd5) begin
                state_d = ST_IDLE;
                bit_d   = 3'd0;
                busy_d  = 1'b0;
            end else begin
                bit_d = bit_q + 3'd1;
                case (bit_q)
                    3'd1:    trig_d = pat_q[2];
                    3'd2:    trig_d = pat_q[1];
                    3'd3:    trig_d = pat_q[0];
                    default: trig_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bit_q       <= 3'd0;
            pat_q       <= 4'd0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            ack_reset_q <= 1'b0;
            ack_align_q <= 1'b0;
            ack_pre_q   <= 1'b0;
            now_q       <= TS_W'(TS_INIT);
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            pre_cnt_q   <= 16'd0;
            l1_cnt_q    <= 16'd0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            pat_q       <= pat_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            ack_reset_q <= gnt_reset;
            ack_align_q <= gnt_align;
            ack_pre_q   <= gnt_pre;
            now_q       <= now_d;
            if (gnt_pre) begin
                wr_q      <= wr_q + 1'b1;
                cnt_q     <= cnt_q + 1'b1;
                pre_cnt_q <= pre_cnt_q + 16'd1;
            end
            if (gnt_l1) begin
                rd_q     <= rd_q + 1'b1;
                cnt_q    <= cnt_q - 1'b1;
                l1_cnt_q <= l1_cnt_q + 16'd1;
                if (since > TS_W'(4)) late_q <= 1'b1;
            end
            // A reset command discards every scheduled L1.
            if (gnt_reset) begin
                rd_q  <= wr_q;
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_pre) fifo_mem[wr_q] <= {now_d + TS_W'(L1_DELAY), ps_flag_i};
    end

    assign ack_reset_o = ack_reset_q;
    assign ack_align_o = ack_align_q;
    assign ack_pre_o   = ack_pre_q;
    assign trigger_o   = trig_q;
    assign busy_o      = busy_q;
    assign pending_o   = cnt_q;
    assign pre_count_o = pre_cnt_q;
    assign l1_count_o  = l1_cnt_q;
    assign late_err_o  = late_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/trig_cmd_scheduler.md
Name: trig_cmd_scheduler

Overview:
- Owns the single serial trigger line to the front-end modules.
- Arbitrates four command sources: reset, align, preL1 and L1.
- Every preL1 it issues automatically schedules the matching L1 a fixed latency later, using a small FIFO of due-times.
- Sits between run-control/test-pulse logic and the trigger output driver.

Parameters:
- L1_DELAY, 325: cycles from the first bit of a preL1 frame to the first bit of its L1 frame; legal range 5..32767.
- DEPTH, 8: number of outstanding scheduled L1s (power of two).
- TS_W, 16: width of the free-running timestamp and of the FIFO entries.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ena  in  1  1 = arbitration enabled; 0 = no new grants (scheduled L1s still go out)
- req_reset  in  1  level request, reset command
- req_align  in  1  level request, align command
- req_pre  in  1  level request, preL1 command
- ps_flag  in  1  sampled with the req_pre grant; the scheduled L1 is sent as "L1 w PS"
- ack_reset  out  1  one-cycle grant pulse
- ack_align  out  1  one-cycle grant pulse
- ack_pre  out  1  one-cycle grant pulse
- trigger  out  1  serial trigger line
- busy  out  1  frame in progress
- pending  out  log2(DEPTH)+1  scheduled L1s not yet sent
- pre_count  out  16  preL1 frames sent, wraps
- l1_count  out  16  L1 frames sent, wraps
- late_err  out  1  sticky; an L1 started more than 4 cycles after its due time

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, timestamp 0, FSM IDLE.
- Timestamp `now`: free-running TS_W counter, wraps.
- Frame = 5 cycles: b1 b2 b3 b4, then guard=0. Patterns (b1..b4):
  - preL1 1110
  - L1 1000
  - L1 w PS 1100
  - align 1010
  - reset 1111
- Idle line: trigger=0.
- FSM states:
  - IDLE: no frame in progress.
  - SEND: bit index 1..5; after the guard cycle returns to IDLE, or grants again on that same edge.
- Grant timing:
  - Evaluated on every edge where the FSM is IDLE or in the guard cycle.
  - On the grant edge, trigger<=b1, the matching ack<=1 for exactly one cycle, busy<=1.
  - Back-to-back frames therefore have a 5-cycle period.
- Priority, highest first:
  1. reset (needs ena)
  2. due L1 (independent of ena)
  3. align (needs ena)
  4. preL1 (needs ena and FIFO not full)
- Due test: FIFO non-empty and (now - head_ts) mod 2^TS_W < 2^(TS_W-1). The test is wrap-safe.
- preL1 grant:
  - Push {now_at_b1 + L1_DELAY, ps_flag}, where now_at_b1 is the timestamp of the cycle b1 is driven.
  - pre_count+1.
- L1 grant:
  - Pop the FIFO head; pattern chosen by the stored ps bit.
  - l1_count+1.
  - If the start is more than 4 cycles after due, set late_err.
- Reset command grant flushes the FIFO: pending<=0, scheduled L1s are discarded.
- FIFO full: req_pre is held off (no ack) until a pop frees an entry. A push and a pop cannot occur on the same edge, since only one grant happens per edge.
- Requesters hold req until ack. A req deasserted before ack is simply not granted. A req still high after ack is treated as a new request.
- ena falling mid-frame: the current frame completes.
- Async reset mid-frame: trigger drops to 0 immediately and no partial frame is resumed.

Test Plan:
- L1_DELAY=20; req_pre pulse held to ack → trigger 1,1,1,0,0 starting cycle T; then 1,0,0,0,0 starting T+20. pre_count=1, l1_count=1, pending 1→0.
- ps_flag=1 on a preL1 grant → the L1 frame is 1,1,0,0,0.
- req_align asserted so the line goes idle exactly on an L1's due edge → L1 frame first; ack_align pulses 5 cycles later, followed by 1,0,1,0,0; late_err stays 0.
- L1_DELAY=200, req_pre held high → 8 back-to-back preL1s at a 5-cycle period, then no ack. The 9th ack arrives on the first edge after the first L1 frame ends; pending never exceeds 8.
- Three preL1s outstanding, then req_reset → frame 1,1,1,1,0; pending=0; no L1s emitted afterwards.
- Timestamp preset near 0xFFF0 with L1_DELAY=40 → L1 is still emitted exactly 40 cycles after its preL1.
- rst pulsed low during b2 of a preL1 → trigger, counters and pending are 0 at once; the line stays idle until a new request.
